// File: rtl/lbp_pkg.sv
// Shared widths and channel state encoding for the LBP pin serializer.
// Imported by the quarter shifter and the serializer top.
package lbp_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int AQTR_W = 4;
  localparam int DQTR_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    Q3,
    Q2,
    Q1,
    Q0
  } ch_state_t;

endpackage

// File: rtl/lbp_qtr_shifter.sv
// One serializer channel: handshake, holding register, MSB-first quarter mux.
// Ports: i_clk, i_rst (async high), i_valid/o_ready, i_gate (extra ready
// qualifier), i_addr, i_data, o_aqtr, o_dqtr, o_strobe (cycle after Q0),
// o_idle.
module lbp_qtr_shifter
  import lbp_pkg::*;
#(
  parameter bit HAS_DATA = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_gate,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [AQTR_W-1:0] o_aqtr,
  output logic [DQTR_W-1:0] o_dqtr,
  output logic              o_strobe,
  output logic              o_idle
);

  ch_state_t         r_state;
  ch_state_t         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_strobe;
  logic              w_take;

  // Q0 can accept so a new Q3 follows with no bubble.
  assign o_ready = !i_rst && i_gate &&
                   (r_state == IDLE || r_state == Q0);
  assign w_take   = i_valid && o_ready;
  assign o_strobe = r_strobe;
  assign o_idle   = (r_state == IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_strobe <= (r_state == Q0);
      if (w_take) begin
        r_addr <= i_addr;
        r_data <= HAS_DATA ? i_data : '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    o_aqtr = '0;
    o_dqtr = '0;
    unique case (r_state)
      IDLE: begin
        if (w_take) w_next = Q3;
      end
      Q3: begin
        w_next = Q2;
        o_aqtr = {2'b00, r_addr[13:12]};
        o_dqtr = r_data[7:6];
      end
      Q2: begin
        w_next = Q1;
        o_aqtr = r_addr[11:8];
        o_dqtr = r_data[5:4];
      end
      Q1: begin
        w_next = Q0;
        o_aqtr = r_addr[7:4];
        o_dqtr = r_data[3:2];
      end
      Q0: begin
        w_next = w_take ? Q3 : IDLE;
        o_aqtr = r_addr[3:0];
        o_dqtr = r_data[1:0];
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: rtl/lbp_pin_serializer.sv
// Pin-mux stage: serializes gray reads and LBP writes onto quarter pins,
// returns gray pixels to the core, and gates O_finish until writes drain.
// Ports: I_clk, I_reset, I_gray_ready, I_gray_data, O_gray_addr_qtr,
// O_gray_req, O_lbp_addr_qtr, O_lbp_data_qtr, O_lbp_valid, O_finish,
// core read (i_rd_*/o_rd_*), core write (i_wr_*/o_wr_ready), i_done.
module lbp_pin_serializer
  import lbp_pkg::*;
(
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_gray_ready,
  input  logic [DATA_W-1:0] I_gray_data,
  output logic [AQTR_W-1:0] O_gray_addr_qtr,
  output logic              O_gray_req,
  output logic [AQTR_W-1:0] O_lbp_addr_qtr,
  output logic [DQTR_W-1:0] O_lbp_data_qtr,
  output logic              O_lbp_valid,
  output logic              O_finish,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_data_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_done
);

  logic              w_rd_strobe;
  logic              w_wr_idle;
  logic [DQTR_W-1:0] w_unused_rd_dq;
  logic              w_unused_rd_idle;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_dv;
  logic              r_done;
  logic              r_finish;

  lbp_qtr_shifter #(
    .HAS_DATA(1'b0)
  ) u_rd (
    .i_clk   (I_clk),
    .i_rst   (I_reset),
    .i_valid (i_rd_valid),
    .i_gate  (I_gray_ready),
    .o_ready (o_rd_ready),
    .i_addr  (i_rd_addr),
    .i_data  ('0),
    .o_aqtr  (O_gray_addr_qtr),
    .o_dqtr  (w_unused_rd_dq),
    .o_strobe(w_rd_strobe),
    .o_idle  (w_unused_rd_idle)
  );

  lbp_qtr_shifter #(
    .HAS_DATA(1'b1)
  ) u_wr (
    .i_clk   (I_clk),
    .i_rst   (I_reset),
    .i_valid (i_wr_valid),
    .i_gate  (1'b1),
    .o_ready (o_wr_ready),
    .i_addr  (i_wr_addr),
    .i_data  (i_wr_data),
    .o_aqtr  (O_lbp_addr_qtr),
    .o_dqtr  (O_lbp_data_qtr),
    .o_strobe(O_lbp_valid),
    .o_idle  (w_wr_idle)
  );

  assign O_gray_req      = w_rd_strobe;
  assign o_rd_data_valid = r_rd_dv;
  assign o_rd_data       = r_rd_data;
  assign O_finish        = r_finish;

  // Memory answers during the strobe cycle; sample at its closing edge.
  // Once the write FSM is back in IDLE no further strobe can follow.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      r_rd_data <= '0;
      r_rd_dv   <= 1'b0;
      r_done    <= 1'b0;
      r_finish  <= 1'b0;
    end else begin
      r_rd_dv <= w_rd_strobe;
      if (w_rd_strobe) r_rd_data <= I_gray_data;
      if (i_done) r_done <= 1'b1;
      if (r_done && w_wr_idle) r_finish <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lbp_pin_serializer.sv
// Randomized + directed bench for lbp_pin_serializer against a
// cycle-scheduled behavioural model and an off-chip combiner model.
module tb_lbp_pin_serializer;

  localparam int MAXC = 16000;
  localparam int INF  = 32'h7fff_ffff;

  logic        I_clk = 1'b0;
  logic        I_reset = 1'b1;
  logic        I_gray_ready = 1'b1;
  logic [7:0]  I_gray_data;
  logic [3:0]  O_gray_addr_qtr;
  logic        O_gray_req;
  logic [3:0]  O_lbp_addr_qtr;
  logic [1:0]  O_lbp_data_qtr;
  logic        O_lbp_valid;
  logic        O_finish;
  logic        i_rd_valid = 1'b0;
  logic        o_rd_ready;
  logic [13:0] i_rd_addr = '0;
  logic        o_rd_data_valid;
  logic [7:0]  o_rd_data;
  logic        i_wr_valid = 1'b0;
  logic        o_wr_ready;
  logic [13:0] i_wr_addr = '0;
  logic [7:0]  i_wr_data = '0;
  logic        i_done = 1'b0;

  lbp_pin_serializer dut (
    .I_clk          (I_clk),
    .I_reset        (I_reset),
    .I_gray_ready   (I_gray_ready),
    .I_gray_data    (I_gray_data),
    .O_gray_addr_qtr(O_gray_addr_qtr),
    .O_gray_req     (O_gray_req),
    .O_lbp_addr_qtr (O_lbp_addr_qtr),
    .O_lbp_data_qtr (O_lbp_data_qtr),
    .O_lbp_valid    (O_lbp_valid),
    .O_finish       (O_finish),
    .i_rd_valid     (i_rd_valid),
    .o_rd_ready     (o_rd_ready),
    .i_rd_addr      (i_rd_addr),
    .o_rd_data_valid(o_rd_data_valid),
    .o_rd_data      (o_rd_data),
    .i_wr_valid     (i_wr_valid),
    .o_wr_ready     (o_wr_ready),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .i_done         (i_done)
  );

  always #5 I_clk = ~I_clk;

  // expected pin values per absolute cycle (cycle c follows edge c)
  logic [3:0] e_gaq [MAXC];
  logic       e_greq[MAXC];
  logic [3:0] e_laq [MAXC];
  logic [1:0] e_ldq [MAXC];
  logic       e_lval[MAXC];
  logic       e_rdv [MAXC];
  logic [7:0] e_rdd [MAXC];
  int         ph_r  [MAXC];
  int         ph_w  [MAXC];

  int  cyc = 0, nerr = 0, nchk = 0;
  int  lastw = -100, fin_start = INF;
  bit  tb_done = 0, chk_en = 0, gaps = 0;
  bit  rst_req = 1, gready = 1, done_req = 0;

  logic [13:0] rq[$];
  logic [13:0] wqa[$];
  logic [7:0]  wqd[$];
  logic [7:0]  gold[int];
  logic [7:0]  lbp_m[int];
  logic [15:0] g_sh = '0, l_sh = '0;
  logic [7:0]  d_sh = '0;
  logic [13:0] g_addr_q = '0;
  int          n_greq = 0, n_lval = 0;
  int          greq_t[$];
  logic [7:0]  rd_got[$];

  logic [3:0] lit_aq[4] = '{4'h2, 4'hA, 4'h5, 4'hC};
  logic [1:0] lit_dq[4] = '{2'd2, 2'd3, 2'd1, 2'd3};
  logic [7:0] lit_rd[3] = '{8'h58, 8'h5B, 8'hD9};

  function automatic logic [7:0] gfun(logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b10} ^ 8'h5A;
  endfunction

  assign I_gray_data = gfun(g_addr_q);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear(int from);
    for (int t = from; t < MAXC; t++) begin
      e_gaq[t] = '0; e_greq[t] = 0; e_laq[t] = '0;
      e_ldq[t] = '0; e_lval[t] = 0; e_rdv[t] = 0;
      e_rdd[t] = '0; ph_r[t] = 0; ph_w[t] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear(cyc);
    rq.delete(); wqa.delete(); wqd.delete();
    tb_done = 0; fin_start = INF; lastw = -100;
  endtask

  task automatic sched_rd(int k, logic [13:0] a);
    for (int j = 0; j < 4; j++) begin
      e_gaq[k+j] = 4'(a >> (12 - 4*j));
      ph_r[k+j]  = j + 1;
    end
    e_greq[k+4] = 1;
    e_rdv[k+5]  = 1;
    e_rdd[k+5]  = gfun(a);
  endtask

  task automatic sched_wr(int k, logic [13:0] a, logic [7:0] d);
    for (int j = 0; j < 4; j++) begin
      e_laq[k+j] = 4'(a >> (12 - 4*j));
      e_ldq[k+j] = 2'(d >> (6 - 2*j));
      ph_w[k+j]  = j + 1;
    end
    e_lval[k+4] = 1;
    gold[int'(a)] = d;
  endtask

  always @(posedge I_clk) cyc++;

  // per-cycle comparison plus off-chip combiner / gray memory model
  always @(negedge I_clk) begin : cmp
    bit ew, er;
    ew = !I_reset && (ph_w[cyc] == 0 || ph_w[cyc] == 4);
    er = !I_reset && I_gray_ready &&
         (ph_r[cyc] == 0 || ph_r[cyc] == 4);
    if (chk_en) begin
      chk("gray_qtr", O_gray_addr_qtr, e_gaq[cyc]);
      chk("gray_req", O_gray_req, e_greq[cyc]);
      chk("lbp_aqtr", O_lbp_addr_qtr, e_laq[cyc]);
      chk("lbp_dqtr", O_lbp_data_qtr, e_ldq[cyc]);
      chk("lbp_valid", O_lbp_valid, e_lval[cyc]);
      chk("rd_ready", o_rd_ready, er);
      chk("wr_ready", o_wr_ready, ew);
      chk("rd_dv", o_rd_data_valid, e_rdv[cyc]);
      if (e_rdv[cyc] || I_reset)
        chk("rd_data", o_rd_data, I_reset ? 8'h00 : e_rdd[cyc]);
      chk("finish", O_finish, !I_reset && cyc >= fin_start);
    end
    assert (!(tb_done && i_wr_valid && !i_done));
    if (O_gray_req) begin
      g_addr_q = g_sh[13:0];
      n_greq++;
      greq_t.push_back(cyc);
    end
    if (O_lbp_valid) begin
      lbp_m[int'(l_sh[13:0])] = d_sh;
      n_lval++;
    end
    if (o_rd_data_valid) rd_got.push_back(o_rd_data);
    g_sh = {g_sh[11:0], O_gray_addr_qtr};
    l_sh = {l_sh[11:0], O_lbp_addr_qtr};
    d_sh = {d_sh[5:0], O_lbp_data_qtr};
  end

  task automatic tick();
    bit vr, vw, ar, aw;
    int k;
    @(posedge I_clk);
    #1;
    I_reset = rst_req;
    I_gray_ready = gready;
    i_done = done_req;
    done_req = 0;
    vr = rq.size() > 0 && (!gaps || $urandom_range(3) != 0);
    vw = wqa.size() > 0 && (!gaps || $urandom_range(3) != 0);
    i_rd_valid = vr;
    i_rd_addr  = vr ? rq[0] : 14'($urandom);
    i_wr_valid = vw;
    i_wr_addr  = vw ? wqa[0] : 14'($urandom);
    i_wr_data  = vw ? wqd[0] : 8'($urandom);
    k  = cyc + 1;
    aw = vw && !I_reset && (ph_w[cyc] == 0 || ph_w[cyc] == 4);
    ar = vr && !I_reset && I_gray_ready &&
         (ph_r[cyc] == 0 || ph_r[cyc] == 4);
    if (ar) sched_rd(k, rq.pop_front());
    if (aw) begin
      sched_wr(k, wqa.pop_front(), wqd.pop_front());
      lastw = k;
    end
    if (i_done) begin
      tb_done = 1;
      fin_start = (k + 1 > lastw + 5) ? k + 1 : lastw + 5;
    end
  endtask

  task automatic at_neg();
    @(negedge I_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int kk, n0, r0, g0, l0, wcnt, rcnt;
    model_clear(0);
    repeat (2) tick();
    chk_en = 1;
    at_neg();
    chk("rst_gaq", O_gray_addr_qtr, 0);
    chk("rst_greq", O_gray_req, 0);
    chk("rst_laq", O_lbp_addr_qtr, 0);
    chk("rst_ldq", O_lbp_data_qtr, 0);
    chk("rst_lval", O_lbp_valid, 0);
    chk("rst_fin", O_finish, 0);
    chk("rst_rrdy", o_rd_ready, 0);
    chk("rst_wrdy", o_wr_ready, 0);
    chk("rst_rdv", o_rd_data_valid, 0);
    chk("rst_rdd", o_rd_data, 0);
    rst_req = 0;
    repeat (2) tick();

    // single write 2A5C/B7
    wqa.push_back(14'h2A5C); wqd.push_back(8'hB7);
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      at_neg();
      chk("w1_aqtr", O_lbp_addr_qtr, lit_aq[j]);
      chk("w1_dqtr", O_lbp_data_qtr, lit_dq[j]);
      chk("w1_val_lo", O_lbp_valid, 0);
    end
    tick();
    at_neg();
    chk("w1_val_hi", O_lbp_valid, 1);
    chk("w1_mem", lbp_m.exists(10844) ? lbp_m[10844] : 8'hxx, 8'hB7);
    repeat (2) tick();

    // back-to-back reads
    n0 = greq_t.size(); r0 = rd_got.size();
    rq.push_back(14'h0000); rq.push_back(14'h3FFF);
    rq.push_back(14'h0081);
    repeat (20) tick();
    chk("b2b_nreq", greq_t.size() - n0, 3);
    chk("b2b_nret", rd_got.size() - r0, 3);
    if (greq_t.size() >= n0 + 3) begin
      chk("b2b_gap1", greq_t[n0+1] - greq_t[n0], 4);
      chk("b2b_gap2", greq_t[n0+2] - greq_t[n0+1], 4);
    end
    if (rd_got.size() >= r0 + 3)
      for (int j = 0; j < 3; j++)
        chk("b2b_data", rd_got[r0+j], lit_rd[j]);

    // concurrent read + write
    rq.push_back(14'h1357);
    wqa.push_back(14'h2468); wqd.push_back(8'h9C);
    tick();
    kk = cyc + 1;
    repeat (5) tick();
    at_neg();
    chk("cc_cycle", cyc, kk + 4);
    chk("cc_greq", O_gray_req, 1);
    chk("cc_lval", O_lbp_valid, 1);
    repeat (3) tick();
    chk("cc_mem", lbp_m.exists(32'h2468) ? lbp_m[32'h2468] : 8'hxx,
        8'h9C);
    chk("cc_rd", rd_got.size() > 0 ? rd_got[$] : 8'hxx, gfun(14'h1357));

    // gray ready dropped during Q2
    g0 = n_greq;
    rq.push_back(14'h0ABC); rq.push_back(14'h0DEF);
    tick();
    tick();
    gready = 0;
    tick();
    repeat (8) tick();
    at_neg();
    chk("gr_rrdy_lo", o_rd_ready, 0);
    chk("gr_one_req", n_greq - g0, 1);
    chk("gr_pending", rq.size(), 1);
    gready = 1;
    repeat (12) tick();
    chk("gr_two_req", n_greq - g0, 2);

    // reset during Q1 of a write
    wqa.push_back(14'h1234); wqd.push_back(8'hC3);
    repeat (4) tick();
    #2;
    chk("rs_preq1", O_lbp_addr_qtr, 4'h3);
    l0 = n_lval;
    I_reset = 1; rst_req = 1;
    model_reset();
    #1;
    chk("rs_laq", O_lbp_addr_qtr, 0);
    chk("rs_ldq", O_lbp_data_qtr, 0);
    chk("rs_wrdy", o_wr_ready, 0);
    chk("rs_lval", O_lbp_valid, 0);
    repeat (3) tick();
    rst_req = 0;
    repeat (6) tick();
    chk("rs_nostrobe", n_lval - l0, 0);
    wqa.push_back(14'h1234); wqd.push_back(8'h5E);
    repeat (8) tick();
    chk("rs_after", n_lval - l0, 1);
    chk("rs_mem", lbp_m.exists(32'h1234) ? lbp_m[32'h1234] : 8'hxx,
        8'h5E);

    // randomized traffic
    gaps = 1; wcnt = 0; rcnt = 0;
    for (int t = 0; t < 12000; t++) begin
      if (wcnt >= 1500 && rcnt >= 1000 &&
          wqa.size() == 0 && rq.size() == 0) break;
      if (wqa.size() < 2 && wcnt < 1500) begin
        wqa.push_back(14'($urandom));
        wqd.push_back(8'($urandom));
        wcnt++;
      end
      if (rq.size() < 2 && rcnt < 1000) begin
        rq.push_back(14'($urandom));
        rcnt++;
      end
      if ($urandom_range(7) == 0) gready = !gready;
      tick();
    end
    gready = 1; gaps = 0;
    repeat (12) tick();
    chk("drain", wqa.size() + rq.size(), 0);
    foreach (gold[a])
      chk("lbp_mem", lbp_m.exists(a) ? lbp_m[a] : 8'hxx, gold[a]);

    // done with the last write
    wqa.push_back(14'h0777); wqd.push_back(8'h11);
    done_req = 1;
    tick();
    kk = cyc + 1;
    repeat (5) tick();
    at_neg();
    chk("fin_cycle", cyc, kk + 4);
    chk("fin_lo", O_finish, 0);
    tick();
    at_neg();
    chk("fin_hi", O_finish, 1);
    repeat (3) tick();
    at_neg();
    chk("fin_hold", O_finish, 1);
    chk("fin_mem", lbp_m.exists(32'h0777) ? lbp_m[32'h0777] : 8'hxx,
        8'h11);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
